// File: rtl/dram_pkg.sv
// Shared constants, instruction field positions and queue FSM encoding for the L2 -> DRAM path.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package dram_pkg;

  localparam int L2_REQ_WIDTH   = 22;
  localparam int DATA_WIDTH     = 8;
  localparam int CONCAT_ADDRESS = 20;

  // Instruction layout: [21] rw (1 = write), [20] reserved, [19:0] bank/row/col.
  localparam int RW_BIT   = 21;
  localparam int ADDR_MSB = 19;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2
  } l2q_state_e;

endpackage

// File: rtl/l2_req_fifo.sv
// Circular buffer of DEPTH request entries with wrapping read/write pointers and an occupancy count.
// Latency: a pushed entry reaches the head on the edge after it is written.
// Backpressure: full/empty are exported; the owner gates push/pop with them.
module l2_req_fifo #(
  parameter  int W     = 30,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int OW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic          full,
  output logic          empty,
  output logic [OW-1:0] occupancy
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;

  // Next storage, pointers and count; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // Entry storage carries no reset; only valid slots are ever read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign head_dat  = mem_q[rd_ptr_q];
  assign full      = (occ_q == OW'(DEPTH));
  assign empty     = (occ_q == '0);
  assign occupancy = occ_q;

endmodule

// File: rtl/l2_req_queue.sv
// L2 request queue feeding dram_ctrl one transaction at a time; returns read data as a 1-cycle pulse. Optional L2Q_TIMEOUT_EN drops unacked heads.
// Latency: accept edge N -> l2_rw_req after edge N+2; ctrl_rsp_valid edge -> rsp_valid after that same edge.
// Backpressure: l2_ready low while the FIFO is full (no same-cycle pop bypass); each request held until cmd_ack.
module l2_req_queue #(
    parameter int L2_REQ_WIDTH = dram_pkg::L2_REQ_WIDTH,
    parameter int DATA_WIDTH   = dram_pkg::DATA_WIDTH,
    parameter int DEPTH        = 4,
    parameter int TIMEOUT_CYC  = 64
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    l2_valid,
    output logic                    l2_ready,
    input  logic [L2_REQ_WIDTH-1:0] l2_instr,
    input  logic [DATA_WIDTH-1:0]   l2_wdata,
    output logic                    l2_rw_req,
    output logic [L2_REQ_WIDTH-1:0] l2_req_instr,
    output logic [DATA_WIDTH-1:0]   l2_req_data,
    input  logic                    cmd_ack,
    input  logic                    ctrl_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   ctrl_rsp_data,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [$clog2(DEPTH):0]  occupancy
`ifdef L2Q_TIMEOUT_EN
    ,
    output logic                    timeout_err
`endif
);
    import dram_pkg::*;

    localparam int EW = L2_REQ_WIDTH + DATA_WIDTH;
    localparam int OW = $clog2(DEPTH) + 1;

    l2q_state_e              state_q, state_d;
    logic                    req_q, req_d;
    logic [L2_REQ_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;

    logic                    push, pop, fifo_full, fifo_empty;
    logic [EW-1:0]           head_dat;
    logic [L2_REQ_WIDTH-1:0] head_instr;
    logic [DATA_WIDTH-1:0]   head_data;
    logic                    ack, tmo_hit;
    logic                    more_after_pop, more_no_pop;

    l2_req_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_b     (rst_b),
        .push      (push),
        .push_dat  ({l2_instr, l2_wdata}),
        .pop       (pop),
        .head_dat  (head_dat),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (occupancy)
    );

    assign push                    = l2_valid && !fifo_full;
    assign l2_ready                = !fifo_full;
    assign {head_instr, head_data} = head_dat;

    // An ack only counts against a request actually being presented.
    assign ack            = cmd_ack && req_q && (state_q == ISSUE);
    // Whether anything remains once the head leaves, counting a same-edge push.
    assign more_after_pop = (occupancy > OW'(1)) || push;
    assign more_no_pop    = !fifo_empty || push;

`ifdef L2Q_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_err_q, tmo_err_d;

    assign tmo_hit = (state_q == ISSUE) && !ack && (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));

    // Wait counter advances only while stuck in ISSUE; any ack, drop or exit clears it. Error is sticky.
    always_comb begin
        tmo_cnt_d = '0;
        tmo_err_d = tmo_err_q || tmo_hit;
        if ((state_q == ISSUE) && !ack && !tmo_hit) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    // Timeout counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign tmo_hit = 1'b0;
`endif

    // Next state, request presentation and read-response capture.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        req_d       = 1'b0;
        instr_d     = instr_q;
        data_d      = data_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (ack || tmo_hit) begin
                    pop = 1'b1;
                    if (ack && !head_instr[RW_BIT]) begin
                        state_d = RD_WAIT;
                    end else begin
                        state_d = more_after_pop ? ISSUE : IDLE;
                    end
                end else begin
                    req_d   = 1'b1;
                    instr_d = head_instr;
                    data_d  = head_data;
                end
            end
            RD_WAIT: begin
                if (ctrl_rsp_valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = ctrl_rsp_data;
                    state_d     = more_no_pop ? ISSUE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and output registers.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            instr_q     <= '0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            instr_q     <= instr_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign l2_rw_req    = req_q;
    assign l2_req_instr = instr_q;
    assign l2_req_data  = data_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;

endmodule

// File: tb/tb_l2_req_queue.sv
// Bench for l2_req_queue: directed corner cases, then randomized traffic against a queue-based model.
// Latency: n/a.
// Backpressure: bench plays both L2 and dram_ctrl.
module tb_l2_req_queue;

    localparam int IW    = 22;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst_b;
    logic          l2_valid;
    logic          l2_ready;
    logic [IW-1:0] l2_instr;
    logic [DW-1:0] l2_wdata;
    logic          l2_rw_req;
    logic [IW-1:0] l2_req_instr;
    logic [DW-1:0] l2_req_data;
    logic          cmd_ack;
    logic          ctrl_rsp_valid;
    logic [DW-1:0] ctrl_rsp_data;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic [2:0]    occupancy;
`ifdef L2Q_TIMEOUT_EN
    logic          timeout_err;
`endif

    l2_req_queue #(.DEPTH(DEPTH), .TIMEOUT_CYC(8)) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .l2_valid       (l2_valid),
        .l2_ready       (l2_ready),
        .l2_instr       (l2_instr),
        .l2_wdata       (l2_wdata),
        .l2_rw_req      (l2_rw_req),
        .l2_req_instr   (l2_req_instr),
        .l2_req_data    (l2_req_data),
        .cmd_ack        (cmd_ack),
        .ctrl_rsp_valid (ctrl_rsp_valid),
        .ctrl_rsp_data  (ctrl_rsp_data),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .occupancy      (occupancy)
`ifdef L2Q_TIMEOUT_EN
        ,
        .timeout_err    (timeout_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int cyc       = 0;
    bit mon_en    = 0;

    // Reference model: queued instructions, entry count, outstanding-read status.
    logic [IW-1:0]    mdl_instr_q[$];
    int               cnt = 0;
    bit               rd_pending = 0;
    bit               rsp_sent = 0;
    int               rd_wait = 0;
    bit               acc_pend = 0, ack_pend = 0, rsp_pend = 0;
    int               vld_pct, ack_pct, rd_pct;

    // Scoreboards: expected issued entries and expected read responses (data + cycle).
    logic [IW+DW-1:0] exp_issue[$];
    logic [DW-1:0]    exp_rsp_dat[$];
    int               exp_rsp_cyc[$];
    logic [IW+DW-1:0] mon_e;
    bit               exp_rv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!l2_rw_req && n < 20) begin
            tick();
            n++;
        end
        chk("wait_req", l2_rw_req, 1);
    endtask

    // One random cycle: retire the handshakes of the edge just passed, then drive the next inputs.
    task automatic step();
        tick();
        if (acc_pend) cnt++;
        if (ack_pend) begin
            logic [IW-1:0] h;
            h = mdl_instr_q.pop_front();
            cnt--;
            if (!h[21]) begin
                rd_pending = 1;
                rsp_sent   = 0;
                rd_wait    = $urandom_range(0, 4);
            end
        end
        if (rsp_pend) rd_pending = 0;
        acc_pend = 0;
        ack_pend = 0;
        rsp_pend = 0;

        l2_instr = {(($urandom_range(99) < rd_pct) ? 1'b0 : 1'b1), 1'b0, 20'($urandom)};
        l2_wdata = 8'($urandom);
        l2_valid = ($urandom_range(99) < vld_pct);
        if (l2_valid && cnt != DEPTH) begin
            acc_pend = 1;
            mdl_instr_q.push_back(l2_instr);
            exp_issue.push_back({l2_instr, l2_wdata});
        end

        cmd_ack = 0;
        if (l2_rw_req) begin
            if ($urandom_range(99) < ack_pct) begin
                cmd_ack  = 1;
                ack_pend = 1;
            end
        end else if ((rd_pending || cnt == 0) && $urandom_range(99) < 10) begin
            cmd_ack = 1;
        end

        ctrl_rsp_valid = 0;
        ctrl_rsp_data  = 8'($urandom);
        if (rd_pending && !rsp_sent) begin
            if (rd_wait == 0) begin
                ctrl_rsp_valid = 1;
                rsp_sent       = 1;
                rsp_pend       = 1;
                exp_rsp_dat.push_back(ctrl_rsp_data);
                exp_rsp_cyc.push_back(cyc + 1);
            end else begin
                rd_wait--;
            end
        end else if (!rd_pending && $urandom_range(99) < 10) begin
            ctrl_rsp_valid = 1;
        end
    endtask

    // Monitor: compares DUT outputs against the model and scoreboards away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("occupancy", occupancy, cnt);
            chk("l2_ready", l2_ready, cnt != DEPTH);
            if (rd_pending) chk("req_during_rd_wait", l2_rw_req, 0);
            if (l2_rw_req && cmd_ack) begin
                if (exp_issue.size() == 0) begin
                    chk("unexpected_issue", 1, 0);
                end else begin
                    mon_e = exp_issue.pop_front();
                    chk("issue_instr", l2_req_instr, mon_e[IW+DW-1:DW]);
                    chk("issue_data", l2_req_data, mon_e[DW-1:0]);
                end
            end
            exp_rv = (exp_rsp_cyc.size() != 0) && (exp_rsp_cyc[0] == cyc);
            chk("rsp_valid", rsp_valid, exp_rv);
            if (exp_rv) begin
                chk("rsp_data", rsp_data, exp_rsp_dat[0]);
                void'(exp_rsp_dat.pop_front());
                void'(exp_rsp_cyc.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_b = 1; l2_valid = 1; l2_instr = 22'h2ABCDE; l2_wdata = 8'hFF;
        cmd_ack = 0; ctrl_rsp_valid = 0; ctrl_rsp_data = 8'h00;
        repeat (3) tick();
        chk("rst_ready", l2_ready, 1);
        chk("rst_occ", occupancy, 0);
        chk("rst_req", l2_rw_req, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_req_instr", l2_req_instr, 0);

        // First write: request presented after edge N+2 with the exact entry.
        rst_b = 0; l2_valid = 0; tick();
        l2_valid = 1; l2_instr = 22'h200123; l2_wdata = 8'hA5; tick();
        l2_valid = 0;
        chk("acc_occ", occupancy, 1);
        chk("req_after_n", l2_rw_req, 0);
        tick(); chk("req_after_n1", l2_rw_req, 0);
        tick(); chk("req_after_n2", l2_rw_req, 1);
        chk("first_instr", l2_req_instr, 22'h200123);
        chk("first_data", l2_req_data, 8'hA5);
        tick(); chk("req_hold", l2_rw_req, 1);
        cmd_ack = 1; tick(); cmd_ack = 0;
        chk("req_drop", l2_rw_req, 0);
        chk("wr_pop_occ", occupancy, 0);

        // Fill to DEPTH with no ack; a fifth request must be refused.
        for (int i = 0; i < 5; i++) begin
            l2_valid = 1; l2_instr = {2'b10, 20'(i * 17 + 3)}; l2_wdata = 8'(8'h10 + i);
            tick();
        end
        l2_valid = 0;
        chk("full_occ", occupancy, 4);
        chk("full_ready", l2_ready, 0);
        for (int i = 0; i < 4; i++) begin
            wait_req();
            chk("fill_order_instr", l2_req_instr, {2'b10, 20'(i * 17 + 3)});
            chk("fill_order_data", l2_req_data, 8'(8'h10 + i));
            cmd_ack = 1; tick(); cmd_ack = 0;
        end
        chk("fill_drain_occ", occupancy, 0);

        // Read with a write queued behind it: no request during RD_WAIT, single response pulse.
        l2_valid = 1; l2_instr = 22'h000045; l2_wdata = 8'h00; tick();
        l2_valid = 0;
        wait_req();
        chk("rd_instr", l2_req_instr, 22'h000045);
        cmd_ack = 1; l2_valid = 1; l2_instr = 22'h2000AA; l2_wdata = 8'h77; tick();
        cmd_ack = 0; l2_valid = 0;
        for (int i = 0; i < 3; i++) begin
            chk("no_req_rd_wait", l2_rw_req, 0);
            chk("no_rsp_early", rsp_valid, 0);
            tick();
        end
        ctrl_rsp_valid = 1; ctrl_rsp_data = 8'h3C; tick();
        ctrl_rsp_valid = 0; ctrl_rsp_data = 8'hEE;
        chk("rsp_pulse", rsp_valid, 1);
        chk("rsp_data_3c", rsp_data, 8'h3C);
        tick();
        chk("rsp_single", rsp_valid, 0);
        chk("rsp_hold", rsp_data, 8'h3C);
        wait_req();
        chk("queued_wr_instr", l2_req_instr, 22'h2000AA);

        // Simultaneous push and pop keeps occupancy.
        l2_valid = 1; l2_instr = 22'h2000BB; l2_wdata = 8'h01; tick();
        chk("occ_two", occupancy, 2);
        l2_instr = 22'h2000CC; l2_wdata = 8'h02; cmd_ack = 1; tick();
        l2_valid = 0; cmd_ack = 0;
        chk("push_pop_occ", occupancy, 2);
        wait_req(); chk("pp_next_bb", l2_req_instr, 22'h2000BB);
        cmd_ack = 1; tick(); cmd_ack = 0;
        wait_req(); chk("pp_next_cc", l2_req_instr, 22'h2000CC);
        cmd_ack = 1; tick(); cmd_ack = 0;

        // Reset while a read is outstanding and a write is queued.
        l2_valid = 1; l2_instr = 22'h0ABCDE; l2_wdata = 8'h00; tick();
        l2_valid = 0;
        wait_req();
        cmd_ack = 1; tick(); cmd_ack = 0;
        l2_valid = 1; l2_instr = 22'h200055; l2_wdata = 8'h55; tick();
        l2_valid = 0;
        rst_b = 1; tick(); rst_b = 0;
        chk("rst_mid_occ", occupancy, 0);
        chk("rst_mid_req", l2_rw_req, 0);
        chk("rst_mid_rsp_valid", rsp_valid, 0);
        chk("rst_mid_rsp_data", rsp_data, 0);
        chk("rst_mid_instr", l2_req_instr, 0);
        chk("rst_mid_ready", l2_ready, 1);
        ctrl_rsp_valid = 1; ctrl_rsp_data = 8'h99; tick();
        ctrl_rsp_valid = 0;
        chk("late_rsp_ignored", rsp_valid, 0);
        chk("late_rsp_data", rsp_data, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lost_entries_no_req", l2_rw_req, 0);
        end

`ifdef L2Q_TIMEOUT_EN
        // Unacked head dropped after 8 ISSUE cycles; error is sticky; next entry issues.
        chk("tmo_err_init", timeout_err, 0);
        l2_valid = 1; l2_instr = 22'h200011; l2_wdata = 8'h11; tick();
        l2_instr = 22'h200022; l2_wdata = 8'h22; tick();
        l2_valid = 0;
        repeat (7) tick();
        chk("tmo_err_before", timeout_err, 0);
        chk("tmo_occ_before", occupancy, 2);
        tick();
        chk("tmo_err_set", timeout_err, 1);
        chk("tmo_occ_after", occupancy, 1);
        wait_req();
        chk("tmo_next_instr", l2_req_instr, 22'h200022);
        cmd_ack = 1; tick(); cmd_ack = 0;
        chk("tmo_err_sticky", timeout_err, 1);
        chk("tmo_final_occ", occupancy, 0);
`endif

        // Randomized traffic in phases of differing pressure.
        cnt = 0; rd_pending = 0; acc_pend = 0; ack_pend = 0; rsp_pend = 0;
        mon_en = 1;
        for (int p = 0; p < 4; p++) begin
            case (p)
                0: begin vld_pct = 60; ack_pct = 50; rd_pct = 40; end
                1: begin vld_pct = 90; ack_pct = 0;  rd_pct = 50; end
                2: begin vld_pct = 80; ack_pct = 90; rd_pct = 30; end
                default: begin vld_pct = 30; ack_pct = 70; rd_pct = 60; end
            endcase
`ifdef L2Q_TIMEOUT_EN
            ack_pct = 100;
`endif
            repeat ((p == 1) ? 40 : 300) step();
        end

        vld_pct = 0; ack_pct = 100; rd_pct = 0;
        begin
            int n = 0;
            while ((cnt != 0 || rd_pending || exp_rsp_cyc.size() != 0) && n < 200) begin
                step();
                n++;
            end
        end
        step();
        step();
        chk("drain_issue_sb_empty", exp_issue.size(), 0);
        chk("drain_rsp_sb_empty", exp_rsp_cyc.size(), 0);
        chk("drain_occ", occupancy, 0);
        mon_en = 0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
